// File: rtl/uart_echo_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_echo_fifo_pkg : shared defaults and FSM encodings for the UART echo block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_echo_fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DROP_W = 16;

  // Default line terminator, shared with other line-oriented UART blocks
  localparam logic [7:0] UART_TERM_CR = 8'h0D;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/uart_echo_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_echo_fifo_if : rx/tx handshake, mode control and status bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_echo_fifo_if
  import uart_echo_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W
) ();
  logic                    rx_ready;
  logic [DATA_W-1:0]       rx_data;
  logic                    tx_busy;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    line_mode;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    overflow;
  logic [DROP_W-1:0]       drop_count;
  logic                    led_r;
  logic                    led_g;

  modport master (
    output rx_ready, rx_data, tx_busy, line_mode,
    input  tx_start, tx_data, fifo_count, overflow, drop_count, led_r, led_g
  );

  modport slave (
    input  rx_ready, rx_data, tx_busy, line_mode,
    output tx_start, tx_data, fifo_count, overflow, drop_count, led_r, led_g
  );
endinterface

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo : synchronous show-ahead FIFO with explicit occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_sync_fifo
  import uart_echo_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic [DATA_W-1:0]      din,
  input  wire logic                   pop,
  output logic      [DATA_W-1:0]      dout,
  output logic      [$clog2(DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; fullness comes from the count alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

`default_nettype wire

// File: rtl/uart_echo_fifo.sv
// ----------------------------------------------------------------------------
// uart_echo_fifo : buffered UART echo engine with line mode and drop accounting
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_echo_fifo
  import uart_echo_fifo_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                DEPTH  = DEF_DEPTH,
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(UART_TERM_CR),
  parameter int                DROP_W = DEF_DROP_W
) (
  input wire logic         clk,
  input wire logic         rst,
  uart_echo_fifo_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [0:0]        r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_led_r;
  logic              r_led_g;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;
  logic [CNT_W-1:0]  r_term_count;

  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_eligible;
  logic              w_pop;
  logic              w_push;
  logic              w_push_term;
  logic              w_pop_term;

  // A full FIFO is released in line mode so a terminator-less stream cannot stall
  always_comb begin
    w_eligible  = bus.line_mode ? ((r_term_count != '0) || w_full) : !w_empty;
    w_pop       = (r_state == ST_IDLE) && w_eligible && !bus.tx_busy;
    w_push      = bus.rx_ready && (!w_full || w_pop);
    w_push_term = w_push && (bus.rx_data == TERM);
    w_pop_term  = w_pop && (w_head == TERM);
  end

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (bus.rx_data),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_led_r      <= 1'b1;
      r_led_g      <= 1'b1;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_term_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_led_r    <= ~w_head[0];
            r_led_g    <= ~w_head[1];
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (bus.tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (bus.rx_ready && !w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
      end

      case ({w_push_term, w_pop_term})
        2'b10:   r_term_count <= r_term_count + CNT_W'(1);
        2'b01:   r_term_count <= r_term_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
  assign bus.led_r      = r_led_r;
  assign bus.led_g      = r_led_g;
endmodule

`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_echo_fifo : self-checking bench with a behavioural uart_tx and echo model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_echo_fifo;
  localparam int DEPTH    = 16;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] stim[$];
  logic       hold   = 1'b0;
  logic       ignore = 1'b0;
  int         busy_cnt = 0;

  uart_echo_fifo_if #(.DATA_W(8), .DEPTH(DEPTH), .DROP_W(16)) bus ();

  uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .TERM(8'h0D), .DROP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: accepts a start when idle and stays busy for BUSY_LEN cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else if (busy_cnt > 0) busy_cnt--;
      else if (bus.tx_start && !ignore && !hold) begin
        got.push_back(bus.tx_data);
        busy_cnt = BUSY_LEN;
      end
      bus.tx_busy = hold || (busy_cnt > 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_stim();
    foreach (stim[i]) begin
      @(negedge clk);
      bus.rx_ready = 1'b1;
      bus.rx_data  = stim[i];
    end
    @(negedge clk);
    bus.rx_ready = 1'b0;
    stim.delete();
  endtask

  task automatic wait_out(input int n, output bit ok);
    int c;
    c = 0;
    while (got.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    tick(BUSY_LEN + 4);
    ok = (got.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
    checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
      errors++; $display("FAIL reset_drop got ovf=%b drops=%0d want 0/0", bus.overflow, bus.drop_count); end
    checks++; if (bus.led_r !== 1'b1 || bus.led_g !== 1'b1) begin
      errors++; $display("FAIL reset_leds got r=%b g=%b want 1/1", bus.led_r, bus.led_g); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_latency();
    bit ok;
    got.delete();
    @(negedge clk);
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h41;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    checks++; if (bus.tx_start !== 1'b0 || bus.fifo_count !== 5'd1) begin
      errors++; $display("FAIL lat_n1 got start=%b count=%0d want 0/1", bus.tx_start, bus.fifo_count); end
    @(negedge clk);
    checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h41) begin
      errors++; $display("FAIL lat_n2 got start=%b data=%h want 1/41", bus.tx_start, bus.tx_data); end
    checks++; if (bus.led_r !== 1'b0 || bus.led_g !== 1'b1) begin
      errors++; $display("FAIL lat_leds got r=%b g=%b want 0/1", bus.led_r, bus.led_g); end
    wait_out(1, ok);
    checks++; if (!ok || got.size() != 1 || got[0] !== 8'h41) begin
      errors++; $display("FAIL lat_echo got %0d words want one 41", got.size()); end
  endtask

  task automatic test_burst();
    got.delete();
    hold = 1'b1;
    tick(2);
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'(i));
    send_stim();
    checks++; if (bus.fifo_count !== 5'd16 || bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
      errors++; $display("FAIL burst_fill got count=%0d ovf=%b drops=%0d want 16/0/0",
                         bus.fifo_count, bus.overflow, bus.drop_count); end
  endtask

  task automatic test_overflow();
    bit ok;
    stim.push_back(8'hEE);
    send_stim();
    checks++; if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd1 || bus.fifo_count !== 5'd16) begin
      errors++; $display("FAIL ovf_state got ovf=%b drops=%0d count=%0d want 1/1/16",
                         bus.overflow, bus.drop_count, bus.fifo_count); end
    hold = 1'b0;
    wait_out(DEPTH, ok);
    tick(30);
    checks++; if (!ok || got.size() != DEPTH) begin
      errors++; $display("FAIL ovf_drain_size got=%0d want=%0d", got.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, got[i], 8'(i)); end
    end
  endtask

  task automatic test_line();
    bit ok;
    got.delete();
    bus.line_mode = 1'b1;
    stim.push_back(8'h61); stim.push_back(8'h62);
    send_stim();
    tick(30);
    checks++; if (got.size() != 0 || bus.tx_start !== 1'b0 || bus.fifo_count !== 5'd2) begin
      errors++; $display("FAIL line_hold got words=%0d start=%b count=%0d want 0/0/2",
                         got.size(), bus.tx_start, bus.fifo_count); end
    stim.push_back(8'h0D);
    send_stim();
    wait_out(3, ok);
    exp_q = '{8'h61, 8'h62, 8'h0D};
    checks++; if (!ok || got.size() != 3) begin errors++; $display("FAIL line_size got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL line_order[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_release();
    bit ok;
    got.delete();
    bus.line_mode = 1'b1;
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'(8'h20 + i));
    send_stim();
    wait_out(1, ok);
    checks++; if (!ok || got[0] !== 8'h20) begin errors++; $display("FAIL full_release got words=%0d want first 20", got.size()); end
    stim.push_back(8'h0D);
    send_stim();
    wait_out(DEPTH + 1, ok);
    checks++; if (!ok || got.size() != DEPTH + 1) begin errors++; $display("FAIL full_drain_size got=%0d want=%0d", got.size(), DEPTH + 1); end
    for (int i = 0; i < got.size() && i <= DEPTH; i++) begin
      logic [7:0] want;
      want = (i == DEPTH) ? 8'h0D : 8'(8'h20 + i);
      checks++; if (got[i] !== want) begin errors++; $display("FAIL full_order[%0d] got=%h want=%h", i, got[i], want); end
    end
    bus.line_mode = 1'b0;
    tick(5);
  endtask

  task automatic test_reset_mid();
    bit ok;
    got.delete();
    ignore = 1'b1;
    stim.push_back(8'h55);
    send_stim();
    tick(3);
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL mid_in_ack got start=%b want=1", bus.tx_start); end
    for (int i = 0; i < 5; i++) stim.push_back(8'(8'h70 + i));
    send_stim();
    checks++; if (bus.fifo_count !== 5'd5) begin errors++; $display("FAIL mid_queued got=%0d want=5", bus.fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_start !== 1'b0 || bus.fifo_count !== 5'd0) begin
      errors++; $display("FAIL mid_reset got start=%b count=%0d want 0/0", bus.tx_start, bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset_drop got ovf=%b drops=%0d want 0/0", bus.overflow, bus.drop_count); end
    rst = 1'b0;
    ignore = 1'b0;
    tick(2);
    stim.push_back(8'h5A);
    send_stim();
    wait_out(1, ok);
    tick(20);
    checks++; if (!ok || got.size() != 1 || got[0] !== 8'h5A) begin
      errors++; $display("FAIL mid_echo got words=%0d want one 5A", got.size()); end
    checks++; if (bus.led_r !== 1'b1 || bus.led_g !== 1'b0) begin
      errors++; $display("FAIL mid_leds got r=%b g=%b want 1/0", bus.led_r, bus.led_g); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    for (int r = 0; r < 8; r++) begin
      got.delete(); exp_q.delete();
      bus.line_mode = (r >= 4);
      if (r < 4) begin
        for (int i = 0; i < $urandom_range(1, DEPTH); i++) begin
          b = 8'($urandom);
          stim.push_back(b); exp_q.push_back(b);
        end
        send_stim();
      end else begin
        for (int i = 0; i < $urandom_range(0, 14); i++) begin
          b = 8'($urandom);
          if (b == 8'h0D) b = 8'h0E;
          stim.push_back(b); exp_q.push_back(b);
        end
        if (stim.size() > 0) send_stim();
        tick(25);
        checks++; if (got.size() != 0) begin errors++; $display("FAIL rnd_line_hold[%0d] got=%0d words want=0", r, got.size()); end
        stim.push_back(8'h0D); exp_q.push_back(8'h0D);
        send_stim();
      end
      wait_out(exp_q.size(), ok);
      checks++; if (!ok || got.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_size[%0d] got=%0d want=%0d", r, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_data[%0d][%0d] got=%h want=%h", r, i, got[i], exp_q[i]); end
      end
      checks++; if (bus.led_r !== ~exp_q[exp_q.size()-1][0] || bus.led_g !== ~exp_q[exp_q.size()-1][1]) begin
        errors++; $display("FAIL rnd_leds[%0d] got r=%b g=%b", r, bus.led_r, bus.led_g); end
    end
    bus.line_mode = 1'b0;
    checks++; if (bus.fifo_count !== 5'd0 || bus.drop_count !== 16'd0) begin
      errors++; $display("FAIL rnd_end got count=%0d drops=%0d want 0/0", bus.fifo_count, bus.drop_count); end
  endtask

  initial begin
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.line_mode = 1'b0;
    test_reset();
    test_latency();
    test_burst();
    test_overflow();
    test_line();
    test_full_release();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
